// File: rtl/stats_pkt_writer_if.sv
// Beat stream and stats FIFO write port of stats_pkt_writer.
// master: beat source plus FIFO (drives pkt_* and stats_fifo_wfull).
// slave : the writer (consumes beats, drives stats_fifo_wen/wdata).
//   pkt_valid/pkt_sop/pkt_eop  beat qualifier and packet framing
//   pkt_mod[2:0]               valid bytes on the eop beat, 0 means 8
//   pkt_err                    eop beat flags an errored packet
//   stats_fifo_wfull           stats FIFO full
//   stats_fifo_wen/wdata       stats FIFO write enable and length entry
interface stats_pkt_writer_if #(
  parameter int unsigned LEN_WIDTH = 14
);
  logic                 pkt_valid;
  logic                 pkt_sop;
  logic                 pkt_eop;
  logic [2:0]           pkt_mod;
  logic                 pkt_err;
  logic                 stats_fifo_wfull;
  logic                 stats_fifo_wen;
  logic [LEN_WIDTH-1:0] stats_fifo_wdata;

  modport master (
    output pkt_valid, pkt_sop, pkt_eop, pkt_mod, pkt_err, stats_fifo_wfull,
    input  stats_fifo_wen, stats_fifo_wdata
  );

  modport slave (
    input  pkt_valid, pkt_sop, pkt_eop, pkt_mod, pkt_err, stats_fifo_wfull,
    output stats_fifo_wen, stats_fifo_wdata
  );
endinterface

// File: rtl/stats_pkt_writer.sv
// Per-packet length producer for the stats FIFO (XGMII clock domain).
// Measures each packet on the 64-bit beat stream, queues the length of every
// good packet in a small hold queue and writes it into the stats FIFO.
// Ports:
//   clk_xgmii      clock, rising edge
//   reset_xgmii_n  asynchronous active-low reset
//   bus            stats_pkt_writer_if.slave (beat stream + FIFO write port)
//   hold_count     hold queue occupancy
//   stats_drop_cnt overflow discard count (only with STATS_WRITER_DROP_CNT_EN)
// Optional feature macro: STATS_WRITER_DROP_CNT_EN.
module stats_pkt_writer #(
  parameter int unsigned LEN_WIDTH  = 14,
  parameter int unsigned HOLD_DEPTH = 2
) (
  input  logic                         clk_xgmii,
  input  logic                         reset_xgmii_n,
  stats_pkt_writer_if.slave            bus,
  output logic [$clog2(HOLD_DEPTH):0] hold_count
`ifdef STATS_WRITER_DROP_CNT_EN
  ,
  output logic [15:0]                  stats_drop_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(HOLD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = LEN_WIDTH + 1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t               r_state, w_state_nxt;
  logic [LEN_WIDTH-1:0] r_acc, w_acc_nxt;
  logic                 w_push;
  logic [LEN_WIDTH-1:0] w_len;

  logic [LEN_WIDTH-1:0] r_mem [HOLD_DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 w_pop, w_full, w_accept;

  logic [3:0]           w_mod_bytes;
  logic [SUM_W-1:0]     w_sum_mod, w_sum_8;
  logic [LEN_WIDTH-1:0] w_acc_plus_mod, w_acc_plus_8;

  // Byte count of the eop beat and saturating accumulator sums.
  always_comb begin
    w_mod_bytes    = (bus.pkt_mod == 3'd0) ? 4'd8 : {1'b0, bus.pkt_mod};
    w_sum_mod      = {1'b0, r_acc} + SUM_W'(w_mod_bytes);
    w_sum_8        = {1'b0, r_acc} + SUM_W'(8);
    w_acc_plus_mod = w_sum_mod[LEN_WIDTH] ? '1 : w_sum_mod[LEN_WIDTH-1:0];
    w_acc_plus_8   = w_sum_8[LEN_WIDTH]   ? '1 : w_sum_8[LEN_WIDTH-1:0];
  end

  // Packet framing state and length accumulator.
  always_ff @(posedge clk_xgmii or negedge reset_xgmii_n) begin
    if (!reset_xgmii_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // Next state; a sop always restarts measurement, dropping any open packet.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_push      = 1'b0;
    w_len       = '0;
    if (bus.pkt_valid) begin
      if (bus.pkt_sop) begin
        if (bus.pkt_eop) begin
          w_state_nxt = IDLE;
          w_push      = ~bus.pkt_err;
          w_len       = LEN_WIDTH'(w_mod_bytes);
        end else begin
          w_state_nxt = IN_PKT;
          w_acc_nxt   = LEN_WIDTH'(8);
        end
      end else if (r_state == IN_PKT) begin
        if (bus.pkt_eop) begin
          w_state_nxt = IDLE;
          w_push      = ~bus.pkt_err;
          w_len       = w_acc_plus_mod;
        end else begin
          w_acc_nxt   = w_acc_plus_8;
        end
      end
    end
  end

  // Pop is decided first so a full queue that pops can still take a push.
  assign w_full   = (r_count == CNT_W'(HOLD_DEPTH));
  assign w_pop    = (r_count != '0) & ~bus.stats_fifo_wfull;
  assign w_accept = w_push & (~w_full | w_pop);

  assign bus.stats_fifo_wen   = w_pop;
  assign bus.stats_fifo_wdata = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign hold_count           = r_count;

  // Hold queue pointers and occupancy.
  always_ff @(posedge clk_xgmii or negedge reset_xgmii_n) begin
    if (!reset_xgmii_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
    end
  end

  // Hold queue storage; contents are meaningless while r_count is 0.
  always_ff @(posedge clk_xgmii) begin
    if (w_accept) r_mem[r_wr_ptr] <= w_len;
  end

`ifdef STATS_WRITER_DROP_CNT_EN
  logic w_drop;
  assign w_drop = w_push & w_full & ~w_pop;

  // Saturating count of lengths lost to hold queue overflow.
  always_ff @(posedge clk_xgmii or negedge reset_xgmii_n) begin
    if (!reset_xgmii_n)                         stats_drop_cnt <= '0;
    else if (w_drop && stats_drop_cnt != 16'hFFFF) stats_drop_cnt <= stats_drop_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/stats_pkt_writer.md
Name: stats_pkt_writer

Overview:
- Producer side of the per-packet statistics FIFO: watches a 64-bit packet beat stream, measures each packet's length in bytes, and writes one length entry per good packet into the stats FIFO.
- One instance per direction (tx and rx), in the XGMII clock domain, writing the FIFO's write port. The wishbone-side stats logic pops these entries and accumulates octet/packet totals.
- Contains a small hold queue so lengths survive short FIFO-full periods.

Parameters:
LEN_WIDTH, 14, width of a length entry; matches the stats FIFO data width.
HOLD_DEPTH, 2, entries in the internal length hold queue (power of 2, >=2).

Ports:
clk_xgmii  input  1  clock; all logic on rising edge
reset_xgmii_n  input  1  asynchronous active-low reset
pkt_valid  input  1  beat qualifier; other pkt_* inputs ignored when low
pkt_sop  input  1  first beat of packet
pkt_eop  input  1  last beat of packet
pkt_mod  input  3  valid bytes on eop beat; 0 means 8
pkt_err  input  1  on eop beat: packet is errored, do not record
stats_fifo_wfull  input  1  stats FIFO full
stats_fifo_wen  output  1  FIFO write enable
stats_fifo_wdata  output  LEN_WIDTH  packet length in bytes
hold_count  output  clog2(HOLD_DEPTH)+1  current hold queue occupancy

Behaviour:
- Reset: clk_xgmii with reset_xgmii_n, asynchronous active-low.
  - State -> IDLE; length accumulator, hold queue pointers and hold_count -> 0.
  - stats_fifo_wen = 0; stats_fifo_wdata = 0.
  - Reset mid-packet discards the packet and all held lengths.
- FSM states: IDLE, IN_PKT.
  - IDLE, valid & sop & !eop -> IN_PKT; accumulator = 8.
  - IDLE, valid & sop & eop -> stay IDLE; single-beat packet of length (mod==0 ? 8 : mod).
  - IDLE, valid & !sop -> ignored.
  - IN_PKT, valid & !sop & !eop -> accumulator += 8.
  - IN_PKT, valid & eop -> length = accumulator + (mod==0 ? 8 : mod); -> IDLE.
  - IN_PKT, valid & sop -> current packet aborted (no entry written); restarts as a new packet, same as the IDLE sop rules.
  - Invalid beats never change state or accumulator.
- Arithmetic: accumulator saturates at 2^LEN_WIDTH-1 and never wraps. The eop addition also saturates.
- Completed length, when pkt_err is low on the eop beat, is pushed into the hold queue at the clock edge ending that beat. pkt_err high drops the packet silently.
- Write port (combinational from registered state):
  - stats_fifo_wen = (hold_count != 0) & !stats_fifo_wfull.
  - stats_fifo_wdata = hold queue head; 0 when the queue is empty.
  - When wen is high, head pops at that edge.
  - Minimum latency: eop beat at cycle N -> wen high in cycle N+1.
- Hold queue is FIFO-ordered, so lengths reach the stats FIFO in packet completion order.
- Simultaneous push and pop:
  - Pop is evaluated first, so a full queue popping in the same cycle still accepts the push.
  - hold_count unchanged.
- Overflow: push while hold_count == HOLD_DEPTH and no pop in that cycle -> new length discarded; queue contents untouched.
- wen is never high while stats_fifo_wfull is high.

Optional Feature:
STATS_WRITER_DROP_CNT_EN
- Defined:
  - Adds output stats_drop_cnt [15:0], reset 0.
  - Increments by 1 on each hold-queue overflow discard; saturates at 16'hFFFF.
  - Errored and aborted packets are not counted.
- Not defined: port absent; overflow discards are silent. All other behaviour identical.

Test Plan:
- Single-beat packet: valid, sop, eop, mod=3, FIFO not full -> next cycle wen=1, wdata=3; hold_count returns to 0.
- 64-byte packet: 8 beats, eop mod=0 -> one write of 64, exactly one wen pulse.
- 1518-byte packet with wfull held high 20 cycles after eop:
  - hold_count=1 and wen=0 while full.
  - wdata=1518 written in the first cycle wfull drops.
- Abort and error cases:
  - sop, 3 beats, second sop, 2-beat packet with mod=5 -> only 13 written.
  - Packet with pkt_err on eop -> nothing written.
- Overflow with wfull stuck high: three 60-byte packets back to back -> hold_count=2, third dropped.
  - With STATS_WRITER_DROP_CNT_EN, stats_drop_cnt=1.
  - On release, writes 60, 60, then idle.
- Saturation/reset:
  - 2100 beats of 8 bytes -> write 16383.
  - reset_xgmii_n asserted mid-packet with 1 entry held -> wen=0, hold_count=0 immediately, no write after release.
